// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/ack handshake and
// issues each word over valid/ready, resolving branches at the issue handshake.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   typedef enum logic [1:0] {
      S_RESET,
      S_FETCH,
      S_ISSUE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] branch_off;
   logic [31:0] pc_inc;

   assign pc_inc     = pc_q + 32'd4;
   // Sign-extended word offset, relative to pc + 4.
   assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         S_RESET: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               state_d = S_FETCH;
               pc_d    = (branch && zero) ? (pc_inc + branch_off) : pc_inc;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign pc_plus4  = pc_inc;
   assign instr     = instr_q;
   assign opcode    = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance with a top-of-memory
// reset PC shares all inputs and is only inspected by the wrap-around test.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_ready;
   logic        branch;
   logic        zero;

   logic        imem_req,   w_imem_req;
   logic [31:0] imem_addr,  w_imem_addr;
   logic [31:0] instr,      w_instr;
   logic [5:0]  opcode,     w_opcode;
   logic        instr_valid, w_instr_valid;
   logic [31:0] pc,         w_pc;
   logic [31:0] pc_plus4,   w_pc_plus4;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch),
      .zero(zero), .pc(pc), .pc_plus4(pc_plus4)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr), .opcode(w_opcode),
      .instr_valid(w_instr_valid), .instr_ready(instr_ready), .branch(branch),
      .zero(zero), .pc(w_pc), .pc_plus4(w_pc_plus4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves both DUTs in S_FETCH at their reset PC with all handshakes idle.
   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // From S_FETCH: zero-wait ack of word w, then handshake with the given branch/zero.
   task automatic issue(input logic [31:0] w, input logic br, input logic z);
      imem_ack = 1'b1; imem_rdata = w; instr_ready = 1'b1;
      tick();
      imem_ack = 1'b0; branch = br; zero = z;
      tick();
      branch = 1'b0; zero = 1'b0; instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      instr_ready = 1'b1; branch = 1'b1; zero = 1'b1;
      tick();
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      vectors++; if (opcode !== 6'd0) begin miscompares++; $display("FAIL rst_opcode: got %0d expected 0", opcode); end
      vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h expected 0", instr); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", pc); end
      vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL rst_pc_plus4: got %h expected 4", pc_plus4); end
      // Ack arriving in S_RESET must not be captured.
      rst = 1'b0; instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
      tick();
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b expected 1", imem_req); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL first_valid: got %b expected 0", instr_valid); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
      imem_ack = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] words [4] = '{32'h8C01_0000, 32'hAC02_0004, 32'h0000_0020, 32'h2003_0005};
      logic [5:0]  ops   [4] = '{6'd35, 6'd43, 6'd0, 6'd8};
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq_fetch[%0d]: req=%b valid=%b expected req=1 valid=0", i, imem_req, instr_valid); end
         vectors++; if (imem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * i)); end
         imem_rdata = words[i];
         tick();
         vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL seq_issue[%0d]: valid=%b req=%b expected valid=1 req=0", i, instr_valid, imem_req); end
         vectors++; if (instr !== words[i]) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, words[i]); end
         vectors++; if (opcode !== ops[i]) begin miscompares++; $display("FAIL seq_opcode[%0d]: got %0d expected %0d", i, opcode, ops[i]); end
         tick();
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
   endtask

   task automatic test_taken_branch();
      do_reset();
      issue(32'h1000_0003, 1'b1, 1'b1);
      vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL br_from0: got %h expected 00000010", imem_addr); end
      issue(32'h1000_0003, 1'b1, 1'b1);
      vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL br_from10: got %h expected 00000020", imem_addr); end
      do_reset();
      issue(32'h1000_0003, 1'b1, 1'b1);
      issue(32'h1000_FFFF, 1'b1, 1'b1);
      vectors++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin miscompares++; $display("FAIL br_self: addr=%h req=%b expected 00000010 1", imem_addr, imem_req); end
      // Negative offset across zero: pc 0 + 4 - 8.
      do_reset();
      issue(32'h1000_FFFE, 1'b1, 1'b1);
      vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL br_neg_wrap: got %h expected fffffffc", imem_addr); end
   endtask

   task automatic test_not_taken();
      do_reset();
      issue(32'h1000_0003, 1'b1, 1'b1);
      issue(32'h1000_0003, 1'b1, 1'b0);
      vectors++; if (imem_addr !== 32'h14) begin miscompares++; $display("FAIL nt_zero0: got %h expected 00000014", imem_addr); end
      do_reset();
      issue(32'h1000_0003, 1'b1, 1'b1);
      issue(32'h1000_0003, 1'b0, 1'b1);
      vectors++; if (imem_addr !== 32'h14) begin miscompares++; $display("FAIL nt_branch0: got %h expected 00000014", imem_addr); end
   endtask

   task automatic test_stalls();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL ack_wait[%0d]: req=%b addr=%h valid=%b expected 1 0 0", i, imem_req, imem_addr, instr_valid); end
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
      tick();
      // Branch/zero and a stray ack during the stall must be ignored.
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; branch = 1'b1; zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_hs[%0d]: valid=%b req=%b expected 1 0", i, instr_valid, imem_req); end
         vectors++; if (instr !== 32'h1000_0003 || pc !== 32'h0) begin miscompares++; $display("FAIL stall_hold[%0d]: instr=%h pc=%h expected 10000003 0", i, instr, pc); end
         tick();
      end
      imem_ack = 1'b0; branch = 1'b0; zero = 1'b0; instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      vectors++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: addr=%h req=%b valid=%b expected 4 1 0", imem_addr, imem_req, instr_valid); end
      vectors++; if (instr !== 32'h1000_0003) begin miscompares++; $display("FAIL stall_instr_kept: got %h expected 10000003", instr); end
   endtask

   task automatic test_wrap();
      do_reset();
      vectors++; if (w_imem_addr !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_first: addr=%h pc_plus4=%h expected fffffffc 0", w_imem_addr, w_pc_plus4); end
      issue(32'h0000_0020, 1'b0, 1'b0);
      vectors++; if (w_imem_addr !== 32'h0 || w_pc_plus4 !== 32'h4 || w_imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_second: addr=%h pc_plus4=%h req=%b expected 0 4 1", w_imem_addr, w_pc_plus4, w_imem_req); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue(32'h1000_000F, 1'b1, 1'b1);
      imem_ack = 1'b1; imem_rdata = 32'h8C00_0000;
      tick();
      vectors++; if (instr_valid !== 1'b1 || pc !== 32'h40) begin miscompares++; $display("FAIL mid_pre: valid=%b pc=%h expected 1 00000040", instr_valid, pc); end
      rst = 1'b1; instr_ready = 1'b1; branch = 1'b1; zero = 1'b1;
      tick();
      vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_rst: valid=%b req=%b expected 0 0", instr_valid, imem_req); end
      vectors++; if (pc !== 32'h0 || opcode !== 6'd0) begin miscompares++; $display("FAIL mid_rst_pc: pc=%h opcode=%0d expected 0 0", pc, opcode); end
      rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
      tick();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_refetch: req=%b addr=%h expected 1 0", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_taken_branch();
      test_not_taken();
      test_stalls();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
